bit3_operand_entry: RTL



---
 rtl/bit3_operand_entry.sv | 110 +++++++++++
 1 files changed

// File: rtl/bit3_operand_entry.sv
// Operand-entry front end for the 3-bit adder board test: synchronizes and
// debounces a push button, then captures operand A, operand B and a valid flag.
module bit3_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw,
  input  logic       btn,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       valid,
  output logic [1:0] state_led
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;
  state_t           state_q, state_d;
  logic [2:0]       a_q, a_d;
  logic [2:0]       b_q, b_d;
  logic             valid_q, valid_d;

  // A level is accepted only after it differs from deb for DEBOUNCE_CYCLES
  // consecutive samples; only the 0->1 acceptance counts as a press.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    press = 1'b0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s2_q;
        press = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (press) begin
          a_d     = sw;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (press) begin
          b_d     = sw;
          valid_d = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        valid_d = 1'b1;
        if (press) begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
      end
      default: begin
        // The unused encoding falls back to LOAD_A; operands are kept.
        state_d = LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= LOAD_A;
      a_q     <= 3'b000;
      b_q     <= 3'b000;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign valid     = valid_q;
  assign state_led = state_q;

endmodule
